// File: rtl/reg_dump_tx.sv
// reg_dump_tx
//
// Sends a debug dump of a register file over a UART 8N1 line. Each dump
// sends one HEADER sync byte first. It then sends registers 0..NUM_REGS-1,
// each as four bytes, most significant byte first. Every byte goes out as a
// standard 8N1 frame: a start bit (0), eight data bits LSB-first, and a stop
// bit (1). Each bit lasts CLKS_PER_BIT clocks.
//
// Ports
//   clk         system clock, rising edge
//   rst         synchronous, active-high reset
//   start       dump request, only looked at while idle
//   reg_addr    debug read address into the register file
//   reg_output  combinational debug read data for reg_addr
//   tx          registered serial output, idles high
//   busy        high while a dump is in progress
//   done        one-cycle pulse when the dump has finished
//
// State      | meaning
// -----------+----------------------------------------------------------
// IDLE       | line idle, waiting for start
// SEND_HDR   | shifting out the HEADER frame
// FETCH      | reg_addr presented, register file read settling
// LOAD       | read data captured into shadow, first byte frame loaded
// SEND_BYTE  | shifting out the four shadow bytes back-to-back
// FINISH     | done pulse, busy already low

module reg_dump_tx #(
    parameter int unsigned CLKS_PER_BIT = 434,
    parameter int unsigned NUM_REGS     = 16,
    parameter logic [7:0]  HEADER       = 8'hA5
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    output logic [3:0]  reg_addr,
    input  logic [31:0] reg_output,
    output logic        tx,
    output logic        busy,
    output logic        done
);

    // Wide enough for CLKS_PER_BIT-1.
    localparam int unsigned     BAUD_W    = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);
    localparam logic [3:0]      LAST_IDX  = 4'(NUM_REGS - 1);
    // Frame bit positions: 0 = start, 1..8 = data, 9 = stop.
    localparam logic [3:0]      STOP_BIT  = 4'd9;

    typedef enum logic [2:0] {
        IDLE,
        SEND_HDR,
        FETCH,
        LOAD,
        SEND_BYTE,
        FINISH
    } state_t;

    state_t              state_q;
    state_t              state_d;

    logic [BAUD_W-1:0]   baud_cnt;
    logic [3:0]          bit_cnt;
    logic [7:0]          shift_q;
    logic                tx_q;
    logic [3:0]          idx_q;
    logic [1:0]          byte_cnt;
    logic [31:0]         shadow_q;

    logic                sending;
    logic                bit_end;
    logic                frame_end;

    logic                load_frame;
    logic [7:0]          frame_byte;
    logic                clr_idx;
    logic                inc_idx;
    logic                capture;
    logic                clr_byte;
    logic                next_byte;

    function automatic logic [7:0] shadow_byte(input logic [31:0] word, input logic [1:0] sel);
        logic [7:0] b;
        case (sel)
            2'd0:    b = word[31:24];
            2'd1:    b = word[23:16];
            2'd2:    b = word[15:8];
            default: b = word[7:0];
        endcase
        return b;
    endfunction

    assign sending   = (state_q == SEND_HDR) || (state_q == SEND_BYTE);
    assign bit_end   = (baud_cnt == BAUD_LAST);
    assign frame_end = sending && bit_end && (bit_cnt == STOP_BIT);

    // ------------------------------------------------------------------
    // Next-state and control decode
    // ------------------------------------------------------------------
    always_comb begin
        state_d    = state_q;
        load_frame = 1'b0;
        frame_byte = 8'h00;
        clr_idx    = 1'b0;
        inc_idx    = 1'b0;
        capture    = 1'b0;
        clr_byte   = 1'b0;
        next_byte  = 1'b0;

        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d    = SEND_HDR;
                    load_frame = 1'b1;
                    frame_byte = HEADER;
                    clr_idx    = 1'b1;
                end
            end

            SEND_HDR: begin
                if (frame_end) begin
                    state_d = FETCH;
                end
            end

            FETCH: begin
                state_d = LOAD;
            end

            LOAD: begin
                // The shadow register and the first frame load on the same
                // edge, so byte 0 comes straight from the read data that is
                // being captured.
                capture    = 1'b1;
                clr_byte   = 1'b1;
                load_frame = 1'b1;
                frame_byte = reg_output[31:24];
                state_d    = SEND_BYTE;
            end

            SEND_BYTE: begin
                if (frame_end) begin
                    if (byte_cnt == 2'd3) begin
                        if (idx_q == LAST_IDX) begin
                            state_d = FINISH;
                        end else begin
                            inc_idx = 1'b1;
                            state_d = FETCH;
                        end
                    end else begin
                        // The next frame's start bit replaces the idle level
                        // on this edge, so there is no gap between the bytes.
                        next_byte  = 1'b1;
                        load_frame = 1'b1;
                        frame_byte = shadow_byte(shadow_q, byte_cnt + 2'd1);
                    end
                end
            end

            FINISH: begin
                state_d = IDLE;
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // State register and datapath
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            baud_cnt <= '0;
            bit_cnt  <= '0;
            shift_q  <= '0;
            tx_q     <= 1'b1;
            idx_q    <= '0;
            byte_cnt <= '0;
            shadow_q <= '0;
        end else begin
            state_q <= state_d;

            if (load_frame) begin
                shift_q  <= frame_byte;
                tx_q     <= 1'b0;
                baud_cnt <= '0;
                bit_cnt  <= '0;
            end else if (sending) begin
                if (bit_end) begin
                    baud_cnt <= '0;
                    if (bit_cnt == STOP_BIT) begin
                        bit_cnt <= '0;
                    end else begin
                        bit_cnt <= bit_cnt + 4'd1;
                    end
                    // Leaving bit k puts bit k+1 on the line. The start bit
                    // and data bits 0..6 are followed by the next data bit.
                    // Data bit 7 is followed by the stop bit, and the stop
                    // bit is followed by idle.
                    if (bit_cnt < 4'd8) begin
                        tx_q    <= shift_q[0];
                        shift_q <= {1'b0, shift_q[7:1]};
                    end else begin
                        tx_q <= 1'b1;
                    end
                end else begin
                    baud_cnt <= baud_cnt + BAUD_W'(1);
                end
            end else begin
                tx_q     <= 1'b1;
                baud_cnt <= '0;
                bit_cnt  <= '0;
            end

            if (clr_idx) begin
                idx_q <= '0;
            end else if (inc_idx) begin
                idx_q <= idx_q + 4'd1;
            end

            if (clr_byte) begin
                byte_cnt <= '0;
            end else if (next_byte) begin
                byte_cnt <= byte_cnt + 2'd1;
            end

            if (capture) begin
                shadow_q <= reg_output;
            end
        end
    end

    assign tx       = tx_q;
    assign reg_addr = idx_q;
    assign busy     = (state_q != IDLE) && (state_q != FINISH);
    assign done     = (state_q == FINISH);

endmodule

// File: tb/tb_reg_dump_tx.sv
// Testbench for reg_dump_tx.
// dut_a: CLKS_PER_BIT=4, NUM_REGS=2, with a two-entry register model.
// dut_b: CLKS_PER_BIT=4, NUM_REGS=16, where register n = {4{n,4'h0}}.
// The stimulus pushes the expected bytes into exp_q. The UART monitor
// decodes the selected DUT's tx and pops exp_q and compares for each byte.
//
// Dump length: the number of edges from the edge that accepts start to the
// edge that raises done is (1+4*N)*10*C + 2*N. Adding the cycle in which
// start is sampled and the done cycle gives (1+4*N)*10*C + 2*N + 2 cycles.
// That is 364 edges for N=2 and 2632 edges for N=16.

module tb_reg_dump_tx;

    localparam int C = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic        sel16 = 1'b0;

    logic        start_a, start_b;
    logic [3:0]  reg_addr_a, reg_addr_b;
    logic [31:0] reg_output_a, reg_output_b;
    logic        tx_a, tx_b, busy_a, busy_b, done_a, done_b;

    logic [31:0] regs2 [0:1];

    logic        mon_tx, busy_sel, done_sel;

    logic [7:0]  exp_q [$];
    int          n_checks = 0;
    int          n_pass = 0;
    int          n_bytes = 0;
    int          mon_gen = 0;
    int          done_cnt = 0;
    int          max_a = 0;
    int          max_b = 0;

    always #5 clk = ~clk;

    assign start_a      = start & ~sel16;
    assign start_b      = start & sel16;
    assign reg_output_a = regs2[reg_addr_a[0]];
    assign reg_output_b = {4{reg_addr_b, 4'h0}};
    assign mon_tx       = sel16 ? tx_b : tx_a;
    assign busy_sel     = sel16 ? busy_b : busy_a;
    assign done_sel     = sel16 ? done_b : done_a;

    reg_dump_tx #(.CLKS_PER_BIT(C), .NUM_REGS(2), .HEADER(8'hA5)) dut_a (
        .clk(clk), .rst(rst), .start(start_a), .reg_addr(reg_addr_a),
        .reg_output(reg_output_a), .tx(tx_a), .busy(busy_a), .done(done_a)
    );

    reg_dump_tx #(.CLKS_PER_BIT(C), .NUM_REGS(16), .HEADER(8'hA5)) dut_b (
        .clk(clk), .rst(rst), .start(start_b), .reg_addr(reg_addr_b),
        .reg_output(reg_output_b), .tx(tx_b), .busy(busy_b), .done(done_b)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    endtask

    task automatic push_word(input logic [31:0] w);
        exp_q.push_back(w[31:24]);
        exp_q.push_back(w[23:16]);
        exp_q.push_back(w[15:8]);
        exp_q.push_back(w[7:0]);
    endtask

    task automatic push_dump2();
        exp_q.push_back(8'hA5);
        push_word(32'h12345678);
        push_word(32'hDEADBEEF);
    endtask

    // Expected tx for sample j after the accepting edge: the header frame,
    // then FETCH and LOAD (idle high), then the start bit of R0 byte 0.
    function automatic logic exp_wave(input int j);
        logic [7:0] h;
        int b;
        h = 8'hA5;
        if (j < 40) begin
            b = j / C;
            if (b == 0) return 1'b0;
            if (b == 9) return 1'b1;
            return h[b-1];
        end
        if (j < 42) return 1'b1;
        return 1'b0;
    endfunction

    always @(negedge clk) begin
        if (done_sel === 1'b1) done_cnt <= done_cnt + 1;
        if (!rst && int'(reg_addr_a) > max_a) max_a <= int'(reg_addr_a);
        if (!rst && int'(reg_addr_b) > max_b) max_b <= int'(reg_addr_b);
    end

    // UART monitor: finds the start bit, samples each bit at its middle,
    // and compares with the scoreboard. A reset during a frame bumps
    // mon_gen, and then the frame is dropped.
    initial begin
        logic [7:0] b;
        logic       stop;
        int         g;
        forever begin
            @(negedge clk);
            if (mon_tx === 1'b0) begin
                g = mon_gen;
                repeat (C / 2) @(negedge clk);
                for (int i = 0; i < 8; i++) begin
                    repeat (C) @(negedge clk);
                    b[i] = mon_tx;
                end
                repeat (C) @(negedge clk);
                stop = mon_tx;
                if (g == mon_gen) begin
                    check("stop_bit", {31'h0, stop}, 32'h1);
                    n_bytes++;
                    if (exp_q.size() == 0) begin
                        n_checks++;
                        $display("FAIL extra_byte: got %h expected none at %0t", b, $time);
                    end else begin
                        check("uart_byte", {24'h0, b}, {24'h0, exp_q.pop_front()});
                    end
                end
            end
        end
    end

    // mode 0 plain, 1 header waveform, 2 mid-dump mutation, 3 start while busy
    task automatic do_dump(input int mode, input int exp_edges, input int limit);
        int j;
        int base;
        base = done_cnt;
        @(negedge clk);
        check("busy_before_start", {31'h0, busy_sel}, 32'h0);
        start = 1'b1;
        @(negedge clk);
        j = 0;
        if (mode != 3) start = 1'b0;
        if (mode == 1) check("busy_after_accept", {31'h0, busy_sel}, 32'h1);
        while (done_sel !== 1'b1 && j < limit) begin
            if (mode == 1 && j <= 42) check("hdr_wave", {31'h0, mon_tx}, {31'h0, exp_wave(j)});
            if (mode == 2 && j == 90) regs2[0] = 32'h0;
            if (mode == 3) start = (j < 300) || (j == 340);
            @(negedge clk);
            j++;
        end
        start = 1'b0;
        check("dump_edges", j, exp_edges);
        check("busy_at_done", {31'h0, busy_sel}, 32'h0);
        @(negedge clk);
        check("done_width", {31'h0, done_sel}, 32'h0);
        repeat (80) @(negedge clk);
        check("queue_drained", exp_q.size(), 0);
        check("done_count", done_cnt - base, 1);
    endtask

    // Reset during data bit 2 of R0 byte 2 (frame starts at j=122), with
    // start held high together with rst.
    task automatic do_reset_abort();
        int j;
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        j = 0;
        while (j < 135) begin
            @(negedge clk);
            j++;
        end
        rst = 1'b1;
        start = 1'b1;
        mon_gen++;
        @(negedge clk);
        check("rst_tx", {31'h0, tx_a}, 32'h1);
        check("rst_busy", {31'h0, busy_a}, 32'h0);
        check("rst_addr", {28'h0, reg_addr_a}, 32'h0);
        check("rst_done", {31'h0, done_a}, 32'h0);
        rst = 1'b0;
        start = 1'b0;
        exp_q.delete();
        repeat (80) @(negedge clk);
        check("rst_idle_tx", {31'h0, tx_a}, 32'h1);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        int nb;
        logic [3:0] n4;
        regs2[0] = 32'h12345678;
        regs2[1] = 32'hDEADBEEF;
        repeat (3) @(negedge clk);
        check("reset_tx_a", {31'h0, tx_a}, 32'h1);
        check("reset_busy_a", {31'h0, busy_a}, 32'h0);
        check("reset_done_a", {31'h0, done_a}, 32'h0);
        check("reset_addr_a", {28'h0, reg_addr_a}, 32'h0);
        check("reset_tx_b", {31'h0, tx_b}, 32'h1);
        check("reset_busy_b", {31'h0, busy_b}, 32'h0);
        rst = 1'b0;
        repeat (5) @(negedge clk);

        push_dump2();
        do_dump(1, 364, 1000);

        push_dump2();
        do_dump(2, 364, 1000);
        regs2[0] = 32'h12345678;

        push_dump2();
        do_dump(3, 364, 1000);

        exp_q.push_back(8'hA5);
        push_word(32'h12345678);
        do_reset_abort();

        push_dump2();
        do_dump(0, 364, 1000);
        check("max_addr_a", max_a, 1);

        sel16 = 1'b1;
        repeat (10) @(negedge clk);
        exp_q.push_back(8'hA5);
        for (int n = 0; n < 16; n++) begin
            n4 = 4'(n);
            push_word({4{n4, 4'h0}});
        end
        nb = n_bytes;
        do_dump(0, 2632, 4000);
        check("bytes_16", n_bytes - nb, 65);
        check("max_addr_b", max_b, 15);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
